// File: rtl/hazard_ctrl_pkg.sv
// Purpose: shared opcode constants, controller state enum and rt-usage helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`include "header.vh"

package hazard_ctrl_pkg;

  localparam int OPCODE_W = `OPCODE_WIDTH;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = `RTYPE;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = `BEQ;
  localparam logic [OPCODE_W-1:0] OP_BNE   = `BNE;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = `LOAD;
  localparam logic [OPCODE_W-1:0] OP_STORE = `STORE;

  typedef enum logic [1:0] {
    ST_RUN     = `HC_RUN,
    ST_LDSTALL = `HC_LDSTALL,
    ST_FLUSH   = `HC_FLUSH,
    ST_MEMWAIT = `HC_MEMWAIT
  } hc_state_e;

  // Instructions that actually read rt as a source operand.
  function automatic logic uses_rt(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_STORE) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Purpose: flag a load-use hazard between the decode and execute instructions.
// Latency: combinational.
// Backpressure: none; hz_o feeds the controller's stall decision.
// Ports: decode valid/opcode/rs/rt, execute opcode/rd/reg_write in; hz_o out.
module hazard_detect
  import hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH = 5
) (
  input  logic                ds_ce_i,
  input  logic [OPCODE_W-1:0] ds_opcode_i,
  input  logic [AWIDTH-1:0]   ds_rs_i,
  input  logic [AWIDTH-1:0]   ds_rt_i,
  input  logic [OPCODE_W-1:0] ex_opcode_i,
  input  logic [AWIDTH-1:0]   ex_rd_i,
  input  logic                ex_reg_write_i,
  output logic                hz_o
);

  logic ex_load_wr;
  logic rs_match;
  logic rt_match;

  // r0 is hardwired, so a load targeting it never creates a dependency.
  assign ex_load_wr = (ex_opcode_i == OP_LOAD) && ex_reg_write_i && (ex_rd_i != '0);
  assign rs_match   = (ex_rd_i == ds_rs_i);
  assign rt_match   = (ex_rd_i == ds_rt_i) && uses_rt(ds_opcode_i);
  assign hz_o       = ds_ce_i && ex_load_wr && (rs_match || rt_match);

endmodule

// File: rtl/header.vh
// Shared opcode and controller-state encodings.
// Opcodes follow the MIPS-style major opcode field used by decode/execute.
// State encodings back the hazard_ctrl_pkg::hc_state_e enum.
`ifndef HAZARD_CTRL_HEADER_VH
`define HAZARD_CTRL_HEADER_VH

`define OPCODE_WIDTH 6

`define RTYPE 6'h00
`define BEQ   6'h04
`define BNE   6'h05
`define LOAD  6'h23
`define STORE 6'h2b

`define HC_RUN     2'd0
`define HC_LDSTALL 2'd1
`define HC_FLUSH   2'd2
`define HC_MEMWAIT 2'd3

`endif

// File: rtl/hazard_ctrl.sv
// Purpose: pipeline sequencer - load-use stalls, memory wait states, branch redirect + flush, perf counters.
// Latency: controls are combinational from state and inputs; state/counters update on the next hc_clk edge.
// Backpressure: hc_i_mem_busy holds fetch/decode/execute/memory until it drops; redirects arriving meanwhile are parked.
// Ports: decode/execute hazard fields, change_pc/alu_pc, mem_busy in;
//        stage stall/flush controls, pc_load/pc_target, stall and redirect counters out.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int AWIDTH      = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int LOAD_LAT    = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 hc_clk,
  input  logic                 hc_rst,
  input  logic                 hc_i_ds_ce,
  input  logic [OPCODE_W-1:0]  hc_i_ds_opcode,
  input  logic [AWIDTH-1:0]    hc_i_ds_rs_addr,
  input  logic [AWIDTH-1:0]    hc_i_ds_rt_addr,
  input  logic [OPCODE_W-1:0]  hc_i_ex_opcode,
  input  logic [AWIDTH-1:0]    hc_i_ex_rd_addr,
  input  logic                 hc_i_ex_reg_write,
  input  logic                 hc_i_change_pc,
  input  logic [PC_WIDTH-1:0]  hc_i_alu_pc,
  input  logic                 hc_i_mem_busy,
  output logic                 hc_o_stall_fs,
  output logic                 hc_o_stall_ds,
  output logic                 hc_o_flush_ds,
  output logic                 hc_o_flush_es,
  output logic                 hc_o_stall_ms,
  output logic                 hc_o_pc_load,
  output logic [PC_WIDTH-1:0]  hc_o_pc_target,
  output logic [CNT_WIDTH-1:0] hc_o_stall_cnt,
  output logic [CNT_WIDTH-1:0] hc_o_redir_cnt
);

  localparam int CNT_MAX = (FLUSH_DEPTH > LOAD_LAT) ? FLUSH_DEPTH : LOAD_LAT;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  hc_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [PC_WIDTH-1:0]  pend_pc_q, pend_pc_d;
  logic                 pl_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] redir_cnt_q, redir_cnt_d;

  logic                 hz;
  logic                 redirect;
  logic [PC_WIDTH-1:0]  redir_pc;

  hazard_detect #(.AWIDTH(AWIDTH)) u_detect (
    .ds_ce_i        (hc_i_ds_ce),
    .ds_opcode_i    (hc_i_ds_opcode),
    .ds_rs_i        (hc_i_ds_rs_addr),
    .ds_rt_i        (hc_i_ds_rt_addr),
    .ex_opcode_i    (hc_i_ex_opcode),
    .ex_rd_i        (hc_i_ex_rd_addr),
    .ex_reg_write_i (hc_i_ex_reg_write),
    .hz_o           (hz)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_d         = pend_q;
    pend_pc_d      = pend_pc_q;
    redirect       = 1'b0;
    redir_pc       = hc_i_alu_pc;
    hc_o_stall_fs  = 1'b0;
    hc_o_stall_ds  = 1'b0;
    hc_o_flush_ds  = 1'b0;
    hc_o_flush_es  = 1'b0;
    hc_o_stall_ms  = 1'b0;
    hc_o_pc_load   = 1'b0;
    hc_o_pc_target = '0;

    unique case (state_q)
      ST_RUN: begin
        // With a single-cycle flush we stay in RUN; pl_q keeps pc_load off two cycles running.
        if (hc_i_change_pc && !pl_q) begin
          redirect = 1'b1;
        end else if (hc_i_mem_busy) begin
          hc_o_stall_fs = 1'b1;
          hc_o_stall_ds = 1'b1;
          hc_o_stall_ms = 1'b1;
          state_d       = ST_MEMWAIT;
        end else if (hz) begin
          hc_o_stall_fs = 1'b1;
          hc_o_stall_ds = 1'b1;
          hc_o_flush_es = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = ST_LDSTALL;
            cnt_d   = CW'(LOAD_LAT - 1);
          end
        end
      end
      ST_LDSTALL: begin
        // A taken branch squashes the stalled decode anyway, so redirect at once.
        if (hc_i_change_pc) begin
          redirect = 1'b1;
        end else begin
          hc_o_stall_fs = 1'b1;
          hc_o_stall_ds = 1'b1;
          hc_o_flush_es = 1'b1;
          cnt_d         = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        hc_o_flush_ds = 1'b1;
        hc_o_flush_es = 1'b1;
        cnt_d         = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_RUN;
      end
      ST_MEMWAIT: begin
        if (hc_i_mem_busy) begin
          hc_o_stall_fs = 1'b1;
          hc_o_stall_ds = 1'b1;
          hc_o_stall_ms = 1'b1;
          if (hc_i_change_pc) begin
            pend_d    = 1'b1;
            pend_pc_d = hc_i_alu_pc;
          end
        end else if (pend_q || hc_i_change_pc) begin
          redirect = 1'b1;
          redir_pc = hc_i_change_pc ? hc_i_alu_pc : pend_pc_q;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (redirect) begin
      hc_o_pc_load   = 1'b1;
      hc_o_pc_target = redir_pc;
      hc_o_flush_ds  = 1'b1;
      hc_o_flush_es  = 1'b1;
      pend_d         = 1'b0;
      if (FLUSH_DEPTH > 1) begin
        state_d = ST_FLUSH;
        cnt_d   = CW'(FLUSH_DEPTH - 1);
      end else begin
        state_d = ST_RUN;
      end
    end

    // Outputs are quiet while reset is held, whatever state is left over.
    if (hc_rst) begin
      hc_o_stall_fs  = 1'b0;
      hc_o_stall_ds  = 1'b0;
      hc_o_flush_ds  = 1'b0;
      hc_o_flush_es  = 1'b0;
      hc_o_stall_ms  = 1'b0;
      hc_o_pc_load   = 1'b0;
      hc_o_pc_target = '0;
    end
  end

  assign stall_cnt_d = (hc_o_stall_ds && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_WIDTH'(1) : stall_cnt_q;
  assign redir_cnt_d = (hc_o_pc_load && (redir_cnt_q != '1)) ? redir_cnt_q + CNT_WIDTH'(1) : redir_cnt_q;

  always_ff @(posedge hc_clk) begin
    if (hc_rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_pc_q   <= '0;
      pl_q        <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      pl_q        <= hc_o_pc_load;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign hc_o_stall_cnt = stall_cnt_q;
  assign hc_o_redir_cnt = redir_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table plus randomized run against a reference model.
// Two instances: defaults (LOAD_LAT=1, FLUSH_DEPTH=2) and a narrow one (LOAD_LAT=3, FLUSH_DEPTH=1, 3-bit counters).
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int PCW = 32;
  localparam int AW  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, ds_ce, ex_rw, cpc, busy;
  logic [OPCODE_W-1:0] ds_op, ex_op;
  logic [AW-1:0]       rs, rt, erd;
  logic [PCW-1:0]      apc;

  logic            a_fs, a_ds, a_fds, a_fes, a_ms, a_pl;
  logic [PCW-1:0]  a_tgt;
  logic [15:0]     a_sc, a_rc;
  logic            b_fs, b_ds, b_fds, b_fes, b_ms, b_pl;
  logic [PCW-1:0]  b_tgt;
  logic [2:0]      b_sc, b_rc;

  hazard_ctrl dut_a (
    .hc_clk(clk), .hc_rst(rst), .hc_i_ds_ce(ds_ce), .hc_i_ds_opcode(ds_op),
    .hc_i_ds_rs_addr(rs), .hc_i_ds_rt_addr(rt), .hc_i_ex_opcode(ex_op),
    .hc_i_ex_rd_addr(erd), .hc_i_ex_reg_write(ex_rw), .hc_i_change_pc(cpc),
    .hc_i_alu_pc(apc), .hc_i_mem_busy(busy),
    .hc_o_stall_fs(a_fs), .hc_o_stall_ds(a_ds), .hc_o_flush_ds(a_fds),
    .hc_o_flush_es(a_fes), .hc_o_stall_ms(a_ms), .hc_o_pc_load(a_pl),
    .hc_o_pc_target(a_tgt), .hc_o_stall_cnt(a_sc), .hc_o_redir_cnt(a_rc)
  );

  hazard_ctrl #(.PC_WIDTH(32), .AWIDTH(5), .FLUSH_DEPTH(1), .LOAD_LAT(3), .CNT_WIDTH(3)) dut_b (
    .hc_clk(clk), .hc_rst(rst), .hc_i_ds_ce(ds_ce), .hc_i_ds_opcode(ds_op),
    .hc_i_ds_rs_addr(rs), .hc_i_ds_rt_addr(rt), .hc_i_ex_opcode(ex_op),
    .hc_i_ex_rd_addr(erd), .hc_i_ex_reg_write(ex_rw), .hc_i_change_pc(cpc),
    .hc_i_alu_pc(apc), .hc_i_mem_busy(busy),
    .hc_o_stall_fs(b_fs), .hc_o_stall_ds(b_ds), .hc_o_flush_ds(b_fds),
    .hc_o_flush_es(b_fes), .hc_o_stall_ms(b_ms), .hc_o_pc_load(b_pl),
    .hc_o_pc_target(b_tgt), .hc_o_stall_cnt(b_sc), .hc_o_redir_cnt(b_rc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining flush / load-stall cycles, a memory-wait flag and a parked redirect.
  typedef struct {
    int         flush_left;
    int         ld_left;
    bit         memwait;
    bit         pend;
    logic [31:0] pend_pc;
    bit         last_load;
    int         scnt;
    int         rcnt;
  } mdl_t;

  // ctl = {stall_fs, stall_ds, flush_ds, flush_es, stall_ms, pc_load}
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] tgt;
  } exp_t;

  typedef struct {
    bit          rst;
    bit          hz;
    bit          hz0;
    bit          cpc;
    logic [31:0] apc;
    bit          busy;
    logic [5:0]  ctl;
    logic [31:0] tgt;
    int          scnt;
    int          rcnt;
  } vec_t;

  mdl_t ma, mb;
  logic [5:0]  snap_a, snap_b;
  logic [31:0] snap_btgt;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit hz_ref();
    bit rt_used;
    rt_used = (ds_op == OP_RTYPE) || (ds_op == OP_STORE) || (ds_op == OP_BEQ) || (ds_op == OP_BNE);
    return ds_ce && (ex_op == OP_LOAD) && ex_rw && (erd != 0) && ((erd == rs) || ((erd == rt) && rt_used));
  endfunction

  task automatic model_step(input mdl_t mi, input int fd, input int ll, input int cmax,
                            output mdl_t mo, output exp_t e);
    bit          redir;
    logic [31:0] pc;
    mo    = mi;
    e.ctl = '0;
    e.tgt = '0;
    redir = 0;
    pc    = apc;
    if (rst) begin
      mo = '{flush_left: 0, ld_left: 0, memwait: 0, pend: 0, pend_pc: 0, last_load: 0, scnt: 0, rcnt: 0};
      return;
    end
    if (mi.flush_left > 0) begin
      e.ctl = 6'b001100;
      mo.flush_left = mi.flush_left - 1;
    end else if (mi.memwait) begin
      if (busy) begin
        e.ctl = 6'b110010;
        if (cpc) begin
          mo.pend    = 1;
          mo.pend_pc = apc;
        end
      end else begin
        mo.memwait = 0;
        if (mi.pend || cpc) begin
          redir = 1;
          pc    = cpc ? apc : mi.pend_pc;
        end
      end
    end else if (mi.ld_left > 0) begin
      if (cpc) redir = 1;
      else begin
        e.ctl      = 6'b110100;
        mo.ld_left = mi.ld_left - 1;
      end
    end else begin
      if (cpc && !mi.last_load) redir = 1;
      else if (busy) begin
        e.ctl      = 6'b110010;
        mo.memwait = 1;
      end else if (hz_ref()) begin
        e.ctl      = 6'b110100;
        mo.ld_left = ll - 1;
      end
    end
    if (redir) begin
      e.ctl         = 6'b001101;
      e.tgt         = pc;
      mo.pend       = 0;
      mo.ld_left    = 0;
      mo.flush_left = fd - 1;
      if (mo.rcnt < cmax) mo.rcnt++;
    end
    if (e.ctl[4] && mo.scnt < cmax) mo.scnt++;
    mo.last_load = e.ctl[0];
  endtask

  task automatic apply_vec(input vec_t v);
    rst   = v.rst;
    ds_ce = v.hz | v.hz0;
    ds_op = OP_RTYPE;
    rs    = 5'd1;
    rt    = 5'd5;
    ex_op = OP_LOAD;
    erd   = v.hz ? 5'd5 : 5'd0;
    ex_rw = 1'b1;
    cpc   = v.cpc;
    apc   = v.apc;
    busy  = v.busy;
  endtask

  task automatic step(input bit use_model, input bit has_vec, input vec_t v);
    exp_t ea, eb;
    mdl_t na, nb;
    @(negedge clk);
    model_step(ma, 2, 1, 16'hffff, na, ea);
    model_step(mb, 1, 3, 7, nb, eb);
    snap_a    = {a_fs, a_ds, a_fds, a_fes, a_ms, a_pl};
    snap_b    = {b_fs, b_ds, b_fds, b_fes, b_ms, b_pl};
    snap_btgt = b_tgt;
    if (use_model) begin
      check("a_ctl",  64'(snap_a), 64'(ea.ctl));
      check("a_tgt",  64'(a_tgt),  64'(ea.tgt));
      check("a_scnt", 64'(a_sc),   64'(ma.scnt));
      check("a_rcnt", 64'(a_rc),   64'(ma.rcnt));
      check("b_ctl",  64'(snap_b), 64'(eb.ctl));
      check("b_tgt",  64'(b_tgt),  64'(eb.tgt));
      check("b_scnt", 64'(b_sc),   64'(mb.scnt));
      check("b_rcnt", 64'(b_rc),   64'(mb.rcnt));
    end
    if (has_vec) begin
      check("vec_ctl",  64'(snap_a), 64'(v.ctl));
      check("vec_tgt",  64'(a_tgt),  64'(v.tgt));
      check("vec_scnt", 64'(a_sc),   64'(v.scnt));
      check("vec_rcnt", 64'(a_rc),   64'(v.rcnt));
    end
    ma = na;
    mb = nb;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OPCODE_W-1:0] pick_op();
    case ($urandom_range(0, 6))
      0, 1:    return OP_LOAD;
      2:       return OP_STORE;
      3:       return OP_RTYPE;
      4:       return OP_BEQ;
      5:       return OP_BNE;
      default: return 6'h08;
    endcase
  endfunction

  vec_t vq[$];
  vec_t idle;
  vec_t v;

  initial begin
    ma = '{flush_left: 0, ld_left: 0, memwait: 0, pend: 0, pend_pc: 0, last_load: 0, scnt: 0, rcnt: 0};
    mb = ma;
    idle = '{0, 0, 0, 0, 32'h0, 0, 6'b0, 32'h0, 0, 0};

    // Initial reset: registers are unknown before the first edge, so no comparisons yet.
    v = idle; v.rst = 1;
    apply_vec(v);
    step(0, 0, v);
    step(0, 0, v);

    // {rst, hz, hz0, cpc, alu_pc, busy, ctl, target, stall_cnt, redir_cnt} for the default instance.
    vq.push_back('{1, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   0, 0});
    vq.push_back('{0, 1, 0, 0, 32'h0,   0, 6'b110100, 32'h0,   0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   1, 0});
    vq.push_back('{0, 0, 1, 0, 32'h0,   0, 6'b000000, 32'h0,   1, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   1, 0});
    vq.push_back('{0, 0, 0, 1, 32'h40,  0, 6'b001101, 32'h40,  1, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b001100, 32'h0,   1, 1});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   1, 1});
    vq.push_back('{0, 0, 0, 0, 32'h0,   1, 6'b110010, 32'h0,   1, 1});
    vq.push_back('{0, 0, 0, 0, 32'h0,   1, 6'b110010, 32'h0,   2, 1});
    vq.push_back('{0, 0, 0, 0, 32'h0,   1, 6'b110010, 32'h0,   3, 1});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   4, 1});
    vq.push_back('{0, 1, 0, 0, 32'h0,   1, 6'b110010, 32'h0,   4, 1});
    vq.push_back('{0, 0, 0, 1, 32'h80,  1, 6'b110010, 32'h0,   5, 1});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b001101, 32'h80,  6, 1});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b001100, 32'h0,   6, 2});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   6, 2});
    vq.push_back('{0, 1, 0, 1, 32'h100, 0, 6'b001101, 32'h100, 6, 2});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b001100, 32'h0,   6, 3});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   6, 3});
    vq.push_back('{0, 0, 0, 1, 32'h44,  0, 6'b001101, 32'h44,  6, 3});
    vq.push_back('{1, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   6, 4});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,   1, 6'b110010, 32'h0,   0, 0});
    vq.push_back('{0, 0, 0, 1, 32'h88,  1, 6'b110010, 32'h0,   1, 0});
    vq.push_back('{1, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   2, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,   1, 6'b110010, 32'h0,   0, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   1, 0});
    vq.push_back('{0, 0, 0, 0, 32'h0,   0, 6'b000000, 32'h0,   1, 0});

    foreach (vq[i]) begin
      apply_vec(vq[i]);
      step(1, 1, vq[i]);
    end

    // Hazard stall length: one bubble cycle on the default instance, three with LOAD_LAT=3.
    begin
      int n_a, n_b;
      n_a = 0;
      n_b = 0;
      for (int i = 0; i < 7; i++) begin
        v = idle;
        v.hz = (i == 0);
        apply_vec(v);
        step(1, 0, v);
        if (snap_a[4]) n_a++;
        if (snap_b[4]) n_b++;
      end
      check("ll1_stall_len", 64'(n_a), 64'd1);
      check("ll3_stall_len", 64'(n_b), 64'd3);
    end

    // Branch during a LOAD_LAT=3 stall aborts the stall and redirects in that cycle.
    v = idle; v.hz = 1;
    apply_vec(v);
    step(1, 0, v);
    v = idle; v.cpc = 1; v.apc = 32'h200;
    apply_vec(v);
    step(1, 0, v);
    check("ldstall_abort_ctl", 64'(snap_b), 64'b001101);
    check("ldstall_abort_tgt", 64'(snap_btgt), 64'h200);
    // FLUSH_DEPTH=1: a second change_pc straight after a redirect must not pulse pc_load again.
    step(1, 0, v);
    check("no_back2back_pl", 64'(snap_b[0]), 64'd0);
    v = idle;
    apply_vec(v);
    step(1, 0, v);

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      ds_ce = ($urandom_range(0, 3) != 0);
      ds_op = pick_op();
      ex_op = pick_op();
      rs    = AW'($urandom_range(0, 3));
      rt    = AW'($urandom_range(0, 3));
      erd   = AW'($urandom_range(0, 3));
      ex_rw = ($urandom_range(0, 3) != 0);
      cpc   = ($urandom_range(0, 6) == 0);
      apc   = $urandom;
      busy  = ($urandom_range(0, 4) == 0);
      step(1, 0, idle);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the fetch/decode/execute/memory stages.
- Detects load-use hazards between decode and execute, and absorbs data-memory wait states.
- Turns execute's branch-taken signal (change_pc, alu_pc) into a PC redirect plus a multi-cycle flush.
- Drives the stage clock-enable/stall/flush controls, including the bubble into execute's ce input. Keeps saturating stall and redirect counters for performance reporting.

Parameters:
- PC_WIDTH, 32, program counter width.
- AWIDTH, 5, register address width.
- FLUSH_DEPTH, 2, cycles of flush after a redirect (>=1).
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard (>=1).
- CNT_WIDTH, 16, perf counter width.

Ports:
- hc_clk  in  1  clock; all state updates on rising edge.
- hc_rst  in  1  synchronous, active-high reset.
- hc_i_ds_ce  in  1  decode holds a valid instruction.
- hc_i_ds_opcode  in  OPCODE_WIDTH  decode-stage opcode.
- hc_i_ds_rs_addr  in  AWIDTH  decode rs.
- hc_i_ds_rt_addr  in  AWIDTH  decode rt.
- hc_i_ex_opcode  in  OPCODE_WIDTH  opcode of instruction in execute.
- hc_i_ex_rd_addr  in  AWIDTH  destination of instruction in execute.
- hc_i_ex_reg_write  in  1  execute instruction writes the register file.
- hc_i_change_pc  in  1  registered branch-taken from execute.
- hc_i_alu_pc  in  PC_WIDTH  branch target from execute.
- hc_i_mem_busy  in  1  data memory not ready.
- hc_o_stall_fs  out  1  hold PC/fetch.
- hc_o_stall_ds  out  1  hold IF/ID register.
- hc_o_flush_ds  out  1  invalidate IF/ID.
- hc_o_flush_es  out  1  drive execute ce low (bubble).
- hc_o_stall_ms  out  1  hold execute/memory registers.
- hc_o_pc_load  out  1  one-cycle PC load strobe.
- hc_o_pc_target  out  PC_WIDTH  PC load value.
- hc_o_stall_cnt  out  CNT_WIDTH  cycles with stall_ds=1.
- hc_o_redir_cnt  out  CNT_WIDTH  redirects performed.

Behaviour:
- FSM states: RUN, LDSTALL, FLUSH, MEMWAIT. Internal counter cnt; pending-redirect flag pend plus pend_pc.
- Reset (also mid-operation): state RUN, cnt 0, pend 0, pend_pc 0, both perf counters 0. All outputs 0, pc_target 0.
- Outputs are combinational from state and inputs (Mealy in RUN). Next-state logic, counters and pend are registered.
- Load-use hazard (hz) = ds_ce && ex_opcode==`LOAD && ex_reg_write && ex_rd!=0 && (ex_rd==ds_rs || (ex_rd==ds_rt && uses_rt)).
- uses_rt is true for `RTYPE, `STORE, `BEQ, `BNE.
- RUN, priority change_pc > mem_busy > hz:
  - change_pc: pc_load=1, pc_target=alu_pc, flush_ds=flush_es=1, redir_cnt++. If FLUSH_DEPTH>1, go FLUSH with cnt=FLUSH_DEPTH-1; else stay RUN.
  - mem_busy: stall_fs=stall_ds=stall_ms=1; go MEMWAIT.
  - hz: stall_fs=stall_ds=1, flush_es=1. If LOAD_LAT>1, go LDSTALL with cnt=LOAD_LAT-1.
- FLUSH: flush_ds=flush_es=1. cnt-- each cycle; at cnt==1, return to RUN. change_pc is ignored in FLUSH, since execute holds only bubbles.
- LDSTALL: stall_fs=stall_ds=flush_es=1. cnt--; at cnt==1, return to RUN.
  - change_pc in LDSTALL: abort the stall and take the RUN redirect action that cycle.
- MEMWAIT: stall_fs=stall_ds=stall_ms=1.
  - change_pc while busy: set pend=1, pend_pc=alu_pc; no pc_load.
  - When mem_busy falls, stalls drop that cycle.
  - If pend or change_pc: perform the redirect (target = change_pc ? alu_pc : pend_pc), clear pend, go FLUSH/RUN as in RUN.
  - Otherwise return to RUN.
- stall_cnt increments every cycle stall_ds=1. Both counters saturate at all-ones.
- pc_load is never asserted two consecutive cycles.

Decomposition:
- Opcode macros (`LOAD, `STORE, `RTYPE, `BEQ, `BNE, `OPCODE_WIDTH) come from header.vh. Add `HC_RUN/`HC_LDSTALL/`HC_FLUSH/`HC_MEMWAIT state encodings there.
- One natural sub-module: hazard_detect, purely combinational, producing hz from the decode/execute fields.

Test Plan:
- Load-use: ex_opcode=`LOAD, ex_rd=5, reg_write=1; decode `RTYPE with rt=5, ds_ce=1 -> stall_fs/stall_ds/flush_es=1 for exactly LOAD_LAT=1 cycle, stall_cnt=1. Same with ex_rd=0 -> no stall.
- Redirect: change_pc=1, alu_pc=0x40 in RUN -> pc_load=1 for one cycle, pc_target=0x40, flush_ds/flush_es high for 2 cycles, redir_cnt=1.
- Mem wait: mem_busy high 3 cycles -> stall_fs/ds/ms high exactly 3 cycles, state back to RUN, stall_cnt=3.
- Simultaneous: mem_busy and hz in the same RUN cycle -> MEMWAIT taken. change_pc(alu_pc=0x80) during MEMWAIT -> no pc_load until busy falls, then pc_load=1, target=0x80.
- Priority: change_pc and hz in the same cycle -> redirect only, no stall, stall_cnt unchanged.
- Reset asserted mid-FLUSH and mid-MEMWAIT -> next cycle all outputs 0, counters 0, pend cleared; with LOAD_LAT=3, the hazard stall lasts exactly 3 cycles.
